// File: rtl/fwperiph_dma_pkg.sv
// fwperiph_dma_pkg: FSM state encodings and channel-select width shared by the DMA arbiter files
package fwperiph_dma_pkg;
    localparam int SEL_W = 5;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
endpackage

// File: rtl/fwperiph_dma_rr_pick.sv
// fwperiph_dma_rr_pick: round-robin pick of the first requester after last, with wrap-around
module fwperiph_dma_rr_pick
    import fwperiph_dma_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             any
);
    logic [N-1:0] sh;
    int c;
    always_comb begin
        idx = '0;
        sh = '0;
        c = 0;
        for (int k = N; k >= 1; k--) begin
            c = (int'(last) + k) % N;
            sh = req >> c;
            idx = sh[0] ? SEL_W'(c) : idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/fwperiph_dma_ch_arb.sv
// fwperiph_dma_ch_arb: round-robin DMA channel arbiter with transfer launch, completion and watchdog abort
module fwperiph_dma_ch_arb
    import fwperiph_dma_pkg::*;
#(
    parameter int CH_COUNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [CH_COUNT-1:0] ch_req,
    output logic [CH_COUNT-1:0] ch_ack,
    output logic [CH_COUNT-1:0] ch_err,
    output logic [SEL_W-1:0]    ch_sel,
    output logic                xfer_start,
    input  logic                xfer_done,
    input  logic                xfer_err,
    output logic                dma_busy,
    output logic                dma_done_all
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [1:0]          state;
    logic [SEL_W-1:0]    last;
    logic [SEL_W-1:0]    pick;
    logic                pick_any;
    logic [CW-1:0]       cnt;
    logic                timeout;
    logic [CH_COUNT-1:0] sel_oh;
    fwperiph_dma_rr_pick #(.N(CH_COUNT)) u_pick (
        .req  (ch_req),
        .last (last),
        .idx  (pick),
        .any  (pick_any)
    );
    assign timeout      = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign sel_oh       = CH_COUNT'(1) << ch_sel;
    assign xfer_start   = state == START;
    assign dma_busy     = state != IDLE;
    assign dma_done_all = (state == IDLE) && (ch_req == '0);
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ch_sel <= '0;
            last   <= SEL_W'(CH_COUNT - 1);
            cnt    <= '0;
            ch_ack <= '0;
            ch_err <= '0;
        end else begin
            ch_ack <= '0;
            ch_err <= '0;
            if (state == IDLE) begin
                if (en && pick_any) begin
                    ch_sel <= pick;
                    state  <= START;
                end
            end else if (state == START) begin
                cnt   <= '0;
                state <= WAIT;
            end else begin
                cnt <= cnt + 1'b1;
                // done outranks a coincident watchdog expiry
                if (xfer_done || timeout) begin
                    ch_ack <= (xfer_done && !xfer_err) ? sel_oh : '0;
                    ch_err <= (xfer_done && !xfer_err) ? '0 : sel_oh;
                    last   <= ch_sel;
                    state  <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fwperiph_dma_ch_arb.sv
// tb_fwperiph_dma_ch_arb: scoreboard bench with a queue-based reference model of the channel arbiter
module tb_fwperiph_dma_ch_arb;
    localparam int CH = 4;
    localparam int TO = 8;
    typedef struct {
        int cyc;
        int ch;
        bit err;
    } exp_t;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [CH-1:0] ch_req = '0;
    logic [CH-1:0] ch_ack;
    logic [CH-1:0] ch_err;
    logic [4:0]    ch_sel;
    logic          xfer_start;
    logic          xfer_done = 1'b0;
    logic          xfer_err = 1'b0;
    logic          dma_busy;
    logic          dma_done_all;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_last = CH - 1;
    exp_t          start_q[$];
    exp_t          out_q[$];
    bit            exp_busy[int];
    bit            exp_dall[int];
    bit            hit;
    logic [CH-1:0] eack;
    logic [CH-1:0] eerr;
    logic [CH-1:0] r;
    bit            e;

    fwperiph_dma_ch_arb #(.CH_COUNT(CH), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .ch_req       (ch_req),
        .ch_ack       (ch_ack),
        .ch_err       (ch_err),
        .ch_sel       (ch_sel),
        .xfer_start   (xfer_start),
        .xfer_done    (xfer_done),
        .xfer_err     (xfer_err),
        .dma_busy     (dma_busy),
        .dma_done_all (dma_done_all)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int rr(input logic [CH-1:0] q);
        for (int k = 1; k <= CH; k++)
            if (q[(m_last + k) % CH]) return (m_last + k) % CH;
        return -1;
    endfunction

    // Scoreboard monitor: every cycle the start/ack/err outputs must match what the queues hold for it
    always @(negedge clock) begin
        hit = start_q.size() > 0 && start_q[0].cyc == cyc;
        chk("xfer_start", 32'(xfer_start), 32'(hit));
        if (hit) begin
            chk("ch_sel", 32'(ch_sel), start_q[0].ch);
            void'(start_q.pop_front());
        end
        hit = out_q.size() > 0 && out_q[0].cyc == cyc;
        eack = (hit && !out_q[0].err) ? CH'(1) << out_q[0].ch : '0;
        eerr = (hit && out_q[0].err) ? CH'(1) << out_q[0].ch : '0;
        chk("ch_ack", 32'(ch_ack), 32'(eack));
        chk("ch_err", 32'(ch_err), 32'(eerr));
        if (hit) void'(out_q.pop_front());
        if (exp_busy.exists(cyc)) chk("dma_busy", 32'(dma_busy), 32'(exp_busy[cyc]));
        if (exp_dall.exists(cyc)) chk("dma_done_all", 32'(dma_done_all), 32'(exp_dall[cyc]));
    end

    task automatic idle(input logic [CH-1:0] q, input bit ena, input int n);
        for (int i = 0; i < n; i++) begin
            ch_req = q;
            en = ena;
            xfer_done = 1'($urandom);
            xfer_err = 1'($urandom);
            exp_busy[cyc] = 1'b0;
            exp_dall[cyc] = q == '0;
            step();
        end
        xfer_done = 1'b0;
    endtask

    // One grant: start lands the cycle after the request; done at WAIT offset k, or the watchdog fires
    task automatic txn(input logic [CH-1:0] q, input int k, input bit err, input bit to);
        int w;
        w = rr(q);
        ch_req = q;
        en = 1'b1;
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        exp_busy[cyc] = 1'b0;
        exp_dall[cyc] = 1'b0;
        start_q.push_back('{cyc + 1, w, 1'b0});
        step();
        xfer_done = 1'($urandom);
        xfer_err = 1'($urandom);
        ch_req = CH'($urandom);
        en = 1'($urandom);
        exp_busy[cyc] = 1'b1;
        exp_dall[cyc] = 1'b0;
        step();
        for (int i = 0; i < TO; i++) begin
            exp_busy[cyc] = 1'b1;
            exp_dall[cyc] = 1'b0;
            xfer_done = !to && i == k;
            xfer_err = (!to && i == k) ? err : 1'($urandom);
            ch_req = CH'($urandom);
            en = 1'($urandom);
            step();
            if (!to && i == k) break;
        end
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        out_q.push_back('{cyc, w, to || err});
        exp_busy[cyc] = 1'b0;
        m_last = w;
    endtask

    task automatic rst_in_wait();
        ch_req = '1;
        en = 1'b1;
        exp_busy[cyc] = 1'b0;
        start_q.push_back('{cyc + 1, rr('1), 1'b0});
        step();
        step();
        exp_busy[cyc] = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_last = CH - 1;
        exp_busy[cyc] = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        chk("rst_ch_sel", 32'(ch_sel), 0);
        chk("rst_ch_ack", 32'(ch_ack), 0);
        chk("rst_ch_err", 32'(ch_err), 0);
        chk("rst_busy", 32'(dma_busy), 0);
        chk("rst_done_all", 32'(dma_done_all), 1);
        repeat (5) txn('1, 1, 1'b0, 1'b0);
        txn(4'b0010, 0, 1'b0, 1'b0);
        txn(4'b1010, 2, 1'b0, 1'b0);
        txn(4'b1010, 0, 1'b0, 1'b0);
        txn(4'b0100, 3, 1'b1, 1'b0);
        txn(4'b0001, 0, 1'b0, 1'b1);
        txn(4'b1000, TO - 1, 1'b0, 1'b0);
        idle(4'b0001, 1'b0, 4);
        txn(4'b0001, 0, 1'b0, 1'b0);
        txn('1, 2, 1'b0, 1'b0);
        rst_in_wait();
        txn('1, 0, 1'b0, 1'b0);
        for (int t = 0; t < 80; t++) begin
            r = CH'($urandom);
            e = ($urandom % 4) != 0;
            if (r == '0 || !e) idle(r, e, int'($urandom_range(1, 3)));
            else txn(r, int'($urandom_range(0, TO - 1)), 1'($urandom), ($urandom % 4) == 0);
        end
        idle('0, 1'b1, 3);
        chk("start_q_drained", start_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fwperiph_dma_ch_arb.md
FWPERIPH_DMA_CH_ARB -- requirements
Module: fwperiph_dma_ch_arb

Interface
- REQ-001: Parameter CH_COUNT, default 4: number of DMA channels; legal range 1..32.
- REQ-002: Parameter TIMEOUT, default 1024: maximum WAIT cycles before abort; 0 disables the watchdog.
- REQ-003: clock  in  1  single clock; all logic is on the rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: en  in  1  global enable; low blocks new grants only.
- REQ-006: ch_req  in  CH_COUNT  per-channel level request (channel enabled and has work).
- REQ-007: ch_ack  out  CH_COUNT  one-hot, one-cycle pulse on successful completion of the granted channel.
- REQ-008: ch_err  out  CH_COUNT  one-hot, one-cycle pulse on an error or timeout on the granted channel.
- REQ-009: ch_sel  out  5  index of the granted channel; held stable from START through the end of WAIT.
- REQ-010: xfer_start  out  1  one-cycle pulse that launches the transfer engine on ch_sel.
- REQ-011: xfer_done  in  1  engine completion pulse.
- REQ-012: xfer_err  in  1  engine error pulse; valid only together with xfer_done.
- REQ-013: dma_busy  out  1  high whenever state != IDLE.
- REQ-014: dma_done_all  out  1  high when state == IDLE and ch_req == 0.

Function
- REQ-015: The FSM SHALL have the states IDLE, START and WAIT.
- REQ-016: IDLE: if en=1 and ch_req!=0, ch_sel SHALL register the round-robin winner and the FSM SHALL go to START; otherwise the FSM stays in IDLE.
- REQ-017: Round-robin order SHALL search from (last+1) mod CH_COUNT upward with wrap-around; last is the most recently completed or aborted channel.
- REQ-018: START: xfer_start SHALL be 1 for exactly this cycle, the watchdog counter SHALL clear, and the FSM SHALL go to WAIT.
- REQ-019: Latency: a request seen in IDLE at cycle N SHALL produce xfer_start at cycle N+1.
- REQ-020: xfer_done asserted during IDLE or START SHALL be ignored.
- REQ-021: WAIT, xfer_done=1 and xfer_err=0: in the next cycle ch_ack[ch_sel] SHALL pulse, last SHALL be set to ch_sel, and the FSM SHALL return to IDLE.
- REQ-022: WAIT, xfer_done=1 and xfer_err=1: the behaviour is as in REQ-021, except that ch_err[ch_sel] pulses instead of ch_ack.
- REQ-023: WAIT with TIMEOUT!=0: the counter SHALL increment every cycle; when the count reaches TIMEOUT-1 without xfer_done, ch_err[ch_sel] SHALL pulse, last SHALL be set to ch_sel, and the FSM SHALL go to IDLE.
- REQ-024: If xfer_done and the timeout occur in the same cycle, done SHALL win.
- REQ-025: ch_req dropping for the granted channel during WAIT SHALL NOT abort the transfer; the arbiter still waits for done or timeout.
- REQ-026: en deasserted during START or WAIT SHALL let the current transfer finish; no new grant is issued while en=0.
- REQ-027: Back-to-back transfers: the minimum spacing between xfer_start pulses SHALL be 3 cycles (WAIT of 1 cycle, IDLE, START).
- REQ-028: With CH_COUNT=1, the arbiter SHALL always select channel 0.
- REQ-029: Unused upper bits of ch_sel SHALL be 0.
- REQ-030: The watchdog counter width SHALL be clog2(TIMEOUT+1), minimum 1 bit.

Reset
- REQ-031: Reset SHALL force: state=IDLE, ch_sel=0, last=CH_COUNT-1 (so channel 0 wins first), counter=0, ch_ack=0, ch_err=0, xfer_start=0.
- REQ-032: Reset asserted in START or WAIT SHALL abandon the transfer, with no ack or err pulse.
- REQ-033: The first grant after reset is evaluated on the first cycle in which reset=0.

Structure
- REQ-034: State encodings (IDLE=0, START=1, WAIT=2) and the ch_sel width constant (5) SHALL live in a shared package, fwperiph_dma_pkg.
- REQ-035: The round-robin search SHALL be a combinational sub-module, fwperiph_dma_rr_pick, with inputs req and last and outputs idx and any.

Verification
- REQ-036: CH_COUNT=4, after reset ch_req=4'b1111 held, every xfer_done given 2 cycles after xfer_start -> ch_sel sequence 0,1,2,3,0; one ch_ack pulse per channel in that order.
- REQ-037: ch_req=4'b1010, last=1 -> grant 3; then with last=3 -> grant 1 (wrap-around skips idle channels).
- REQ-038: TIMEOUT=8, no xfer_done -> ch_err[ch_sel] pulses 8 cycles after entering WAIT; dma_busy falls in the same cycle.
- REQ-039: xfer_done=1 with xfer_err=1 on ch 2 -> ch_err=4'b0100 pulses and ch_ack stays 0; xfer_done in the timeout cycle -> ch_ack, not ch_err.
- REQ-040: en=0 with ch_req=4'b0001 -> no xfer_start and dma_done_all=0; en=1 -> xfer_start asserts one cycle after the IDLE cycle that samples en=1.
- REQ-041: reset pulsed in WAIT -> next cycle state=IDLE, no ack or err pulse; the next grant goes to channel 0.
